ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_reader.sv | 139 +++++++++++++
 tb/tb_ram_burst_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_reader
// Purpose  : Streams a burst of words from a 1-cycle-latency sync RAM through
//            a small output FIFO with valid/ready flow control.
// Revision : 1.0
// ============================================================================
module ram_burst_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_read,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0]  c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
  localparam logic [ADDR_WIDTH:0] c_LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_inflight;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic w_start_burst;
  logic w_start_empty;
  logic w_room;
  logic w_last_issue;
  logic w_push;
  logic w_pop;
  logic w_last_pop;

  assign w_start_burst = (r_state == S_IDLE) && start && (length != '0);
  assign w_start_empty = (r_state == S_IDLE) && start && (length == '0);
  // Reserve a slot for the read already in flight so the FIFO cannot overflow.
  assign w_room        = (r_count + c_CNT_W'(r_inflight)) < c_DEPTH;
  assign w_last_issue  = ram_read && (r_remaining == c_LEN_ONE);
  assign w_push        = r_inflight;
  assign w_pop         = out_valid && out_ready;
  assign w_last_pop    = (r_state == S_DRAIN) && w_pop && (r_count == c_CNT_ONE) && !r_inflight;

  assign ram_addr  = r_addr;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_burst) w_next_state = S_READ;
      S_READ:  if (w_last_issue)  w_next_state = S_DRAIN;
      S_DRAIN: if (w_last_pop)    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ram_read = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_READ: begin
        ram_read = w_room;
        busy     = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      default: begin
        ram_read = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_done     <= w_start_empty || w_last_pop;
      r_inflight <= ram_read;
      if (w_start_burst) begin
        r_addr      <= base_addr;
        r_remaining <= length;
      end else if (ram_read) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= ram_dout;
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_burst_reader
// Purpose  : Directed self-checking bench for ram_burst_reader (RAM word i = 2i+1).
// Revision : 1.0
// ============================================================================
module tb_ram_burst_reader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [AW-1:0] ram_addr;
  logic          ram_read;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  int got [64];
  int got_cyc [64];
  int n_got;
  int done_cnt;
  int done_cyc;
  bit busy_at_done;
  int reads_hold;
  bit hold_changed;
  int hold_first;
  int hold_cycles;
  int restart_at;

  ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .ram_addr(ram_addr), .ram_read(ram_read), .ram_dout(ram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Sync RAM model, one-cycle latency, word i holds 2i+1.
  always @(posedge clk) if (ram_read) ram_dout <= {21'd0, ram_addr, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int base, input int len);
    base_addr = AW'(base);
    length    = (AW+1)'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Records accepted words, done pulses and read activity; cycle 0 is the cycle after start.
  task automatic observe(input int budget);
    n_got = 0; done_cnt = 0; done_cyc = -1; busy_at_done = 1'b1;
    reads_hold = 0; hold_changed = 1'b0; hold_first = -1;
    for (int i = 0; i < 64; i++) begin got[i] = -1; got_cyc[i] = -1; end
    for (int c = 0; c < budget; c++) begin
      out_ready = (c >= hold_cycles);
      if (c == restart_at) begin start = 1'b1; base_addr = AW'(500); length = (AW+1)'(3); end
      else if (c == restart_at + 3) start = 1'b0;
      if (ram_read && c < hold_cycles) reads_hold++;
      if (out_valid && c < hold_cycles) begin
        if (hold_first < 0) hold_first = int'(out_data);
        else if (int'(out_data) != hold_first) hold_changed = 1'b1;
      end
      if (out_valid && out_ready && n_got < 64) begin
        got[n_got] = int'(out_data); got_cyc[n_got] = c; n_got++;
      end
      if (done) begin done_cnt++; done_cyc = c; busy_at_done = busy; end
      if (done_cnt > 0 && c > done_cyc + 2) break;
      tick();
    end
    out_ready = 1'b1;
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; base_addr = AW'(7); length = (AW+1)'(4); out_ready = 1'b1;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (ram_read !== 1'b0) begin bad++; $display("FAIL reset_ram_read: got %b want 0", ram_read); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (ram_addr !== '0) begin bad++; $display("FAIL reset_ram_addr: got %0d want 0", ram_addr); end
    rst = 1'b0; start = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_overridden: busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int exp [4] = '{1, 3, 5, 7};
    hold_cycles = 0; restart_at = -10;
    start_burst(0, 4);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    observe(40);
    total++; if (n_got !== 4) begin bad++; $display("FAIL basic_count: got %0d want 4", n_got); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL basic_word%0d: got %0d want %0d", i, got[i], exp[i]); end
    end
    total++; if (got_cyc[0] !== 2) begin bad++; $display("FAIL basic_latency: got cycle %0d want 2", got_cyc[0]); end
    total++; if (got_cyc[3] !== 5) begin bad++; $display("FAIL basic_back_to_back: last word cycle %0d want 5", got_cyc[3]); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    total++; if (done_cyc !== 6) begin bad++; $display("FAIL basic_done_cycle: got %0d want 6", done_cyc); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
  endtask

  task automatic test_wrap();
    int exp [4] = '{2045, 2047, 1, 3};
    hold_cycles = 0; restart_at = -10;
    start_burst(1022, 4);
    observe(40);
    total++; if (n_got !== 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", n_got); end
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL wrap_word%0d: got %0d want %0d", i, got[i], exp[i]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    hold_cycles = 10; restart_at = -10;
    start_burst(0, 8);
    observe(80);
    hold_cycles = 0;
    total++; if (reads_hold > FD + 1) begin bad++; $display("FAIL bp_reads_while_stalled: got %0d want <= %0d", reads_hold, FD + 1); end
    total++; if (hold_first !== 1) begin bad++; $display("FAIL bp_held_head: got %0d want 1", hold_first); end
    total++; if (hold_changed !== 1'b0) begin bad++; $display("FAIL bp_head_stable: changed=%b want 0", hold_changed); end
    total++; if (n_got !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      total++; if (got[i] !== 2 * i + 1) begin bad++; $display("FAIL bp_word%0d: got %0d want %0d", i, got[i], 2 * i + 1); end
    end
    total++; if (got_cyc[0] !== 10) begin bad++; $display("FAIL bp_first_accept: got cycle %0d want 10", got_cyc[0]); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_len();
    start_burst(3, 0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done_pulse: got %b want 1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy); end
    total++; if (ram_read !== 1'b0) begin bad++; $display("FAIL zero_ram_read: got %b want 0", ram_read); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_single: got %b want 0", done); end
    total++; if (busy !== 1'b0 || ram_read !== 1'b0) begin
      bad++; $display("FAIL zero_idle_after: busy=%b ram_read=%b want 0 0", busy, ram_read);
    end
  endtask

  task automatic test_ignore_start();
    hold_cycles = 0; restart_at = 2;
    start_burst(100, 6);
    observe(60);
    restart_at = -10;
    total++; if (n_got !== 6) begin bad++; $display("FAIL ignore_count: got %0d want 6", n_got); end
    for (int i = 0; i < 6; i++) begin
      total++; if (got[i] !== 2 * (100 + i) + 1) begin
        bad++; $display("FAIL ignore_word%0d: got %0d want %0d", i, got[i], 2 * (100 + i) + 1);
      end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_new_burst: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit stray = 1'b0;
    hold_cycles = 0; restart_at = -10;
    start_burst(0, 6);
    for (int c = 0; c < 20 && n < 2; c++) begin
      if (out_valid && out_ready) n++;
      tick();
    end
    total++; if (n !== 2) begin bad++; $display("FAIL midrst_words_before: got %0d want 2", n); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
    for (int c = 0; c < 6; c++) begin
      if (done || out_valid || ram_read) stray = 1'b1;
      tick();
    end
    total++; if (stray !== 1'b0) begin bad++; $display("FAIL midrst_quiet: activity=%b want 0", stray); end
    start_burst(5, 2);
    observe(30);
    total++; if (n_got !== 2) begin bad++; $display("FAIL midrst_new_count: got %0d want 2", n_got); end
    total++; if (got[0] !== 11) begin bad++; $display("FAIL midrst_new_word0: got %0d want 11", got[0]); end
    total++; if (got[1] !== 13) begin bad++; $display("FAIL midrst_new_word1: got %0d want 13", got[1]); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL midrst_new_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    hold_cycles = 0; restart_at = -10;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_ignore_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
